// File: rtl/grant_pkg.sv
// grant_pkg: shared tenure FSM states, user one-hot codes and grant legality check
package grant_pkg;
  typedef enum logic [1:0] {IDLE, OWN, RELEASE} tenure_state_t;
  localparam logic [3:0] G_U1 = 4'b1000;
  localparam logic [3:0] G_U2 = 4'b0100;
  localparam logic [3:0] G_U3 = 4'b0010;
  localparam logic [3:0] G_U4 = 4'b0001;
  function automatic logic onehot4(input logic [3:0] g);
    return (g != 4'd0) && ((g & (g - 4'd1)) == 4'd0);
  endfunction
endpackage

// File: rtl/tenure_timer.sv
// tenure_timer: owner tenure countdown; load sets TENURE-1, dec counts down, zero flags the last cycle
//   clock, reset : clock and synchronous active-high reset
//   load, dec    : reload (priority) and decrement strobes
//   zero         : timer value is zero
module tenure_timer #(
  parameter int TENURE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);
  logic [7:0] t;
  always_ff @(posedge clock) begin
    if (reset) t <= '0;
    else if (load) t <= 8'(TENURE - 1);
    else if (dec) t <= t - 8'd1;
  end
  assign zero = t == 8'd0;
endmodule

// File: rtl/grant_tenure.sv
// grant_tenure: turns arbiter grants into bounded one-hot bus tenures with a one-deep pending buffer
//   clock, reset : clock and synchronous active-high reset
//   GRANT_I      : arbiter grant (bit 3 = user 1), one-hot or zero
//   DONE         : early release by the current owner
//   OWNER        : one-hot bus owner; OWNER_VALID high while owned
//   ERR_GRANT    : sticky illegal-grant flag; OVERRUN : sticky pending-overwrite flag
//   SERVED       : per-user tenure counts, user 1 in the MSBs (only with GRANT_TENURE_STATS_EN)
module grant_tenure
  import grant_pkg::*;
#(
  parameter int TENURE = 4
`ifdef GRANT_TENURE_STATS_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] GRANT_I,
  input  logic       DONE,
  output logic [3:0] OWNER,
  output logic       OWNER_VALID,
  output logic       ERR_GRANT,
  output logic       OVERRUN
`ifdef GRANT_TENURE_STATS_EN
  , output logic [4*CNT_W-1:0] SERVED
`endif
);
  tenure_state_t state, nxt;
  logic [3:0] grant_q, pend_u, pu_d, owner_d;
  logic pend_v, pv_d, ovr_set, load, dec, tz, ev, bad;
  assign ev = (GRANT_I != grant_q) && onehot4(GRANT_I);
  assign bad = (GRANT_I != 4'd0) && !onehot4(GRANT_I);
  tenure_timer #(.TENURE(TENURE)) u_timer (
    .clock(clock),
    .reset(reset),
    .load(load),
    .dec(dec),
    .zero(tz)
  );
  always_comb begin
    nxt = state;
    owner_d = OWNER;
    pv_d = pend_v;
    pu_d = pend_u;
    ovr_set = 1'b0;
    load = 1'b0;
    dec = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend_v) begin
          // older buffered grant goes first; a same-cycle event refills the buffer
          nxt = OWN;
          owner_d = pend_u;
          load = 1'b1;
          pv_d = ev;
          pu_d = ev ? GRANT_I : pend_u;
        end else if (ev) begin
          nxt = OWN;
          owner_d = GRANT_I;
          load = 1'b1;
        end
      end
      OWN: begin
        if (DONE || tz) begin
          nxt = RELEASE;
          owner_d = 4'd0;
        end else dec = 1'b1;
        if (ev) begin
          pv_d = 1'b1;
          pu_d = GRANT_I;
          ovr_set = pend_v;
        end
      end
      RELEASE: begin
        nxt = IDLE;
        if (ev) begin
          pv_d = 1'b1;
          pu_d = GRANT_I;
          ovr_set = pend_v;
        end
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      OWNER <= '0;
      grant_q <= '0;
      pend_v <= 1'b0;
      pend_u <= '0;
      ERR_GRANT <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      state <= nxt;
      OWNER <= owner_d;
      grant_q <= GRANT_I;
      pend_v <= pv_d;
      pend_u <= pu_d;
      ERR_GRANT <= ERR_GRANT | bad;
      OVERRUN <= OVERRUN | ovr_set;
    end
  end
  assign OWNER_VALID = state == OWN;
`ifdef GRANT_TENURE_STATS_EN
  logic [CNT_W-1:0] cnt [4];
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++)
      if (reset) cnt[i] <= '0;
      else if (load && owner_d[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
  end
  always_comb
    for (int i = 0; i < 4; i++) SERVED[i*CNT_W +: CNT_W] = cnt[i];
`endif
endmodule
